// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the 8259A-style interrupt acknowledge sequencer.
// Levels are physical IR indices; index 0 is the highest priority.
package interrupt_ack_sequencer_pkg;

    localparam int NUM_IRQ = 8;
    localparam int LVL_W   = 3;
    localparam int BASE_W  = 5;

    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_PEND = 2'd1,
        WAIT2    = 2'd2,
        VEC      = 2'd3
    } state_e;

    function automatic logic [NUM_IRQ-1:0] lvl_mask(input logic [LVL_W-1:0] lvl);
        return NUM_IRQ'(1) << lvl;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Resolver/CPU-facing signal bundle of the acknowledge sequencer.
// master = resolver, register file and CPU side; slave = the sequencer.
interface interrupt_ack_sequencer_if;
    import interrupt_ack_sequencer_pkg::*;

    // req_valid is a level held while the resolver has a winner; eoi_valid,
    // irr_clear, rotate_valid and spurious are single-cycle strobes with no back-pressure.
    logic               req_valid;
    logic [LVL_W-1:0]   req_level;
    logic [BASE_W-1:0]  icw2_base;
    logic               aeoi;
    logic               inta_n;
    logic               eoi_valid;
    logic               eoi_specific;
    logic [LVL_W-1:0]   eoi_level;
    logic               eoi_rotate;
    logic               int_out;
    logic [7:0]         data_out;
    logic               data_oe;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] irr_clear;
    logic               rotate_valid;
    logic [LVL_W-1:0]   rotate_level;
    logic               spurious;
    state_e             dbg_state;

    modport master (
        output req_valid, req_level, icw2_base, aeoi, inta_n,
               eoi_valid, eoi_specific, eoi_level, eoi_rotate,
        input  int_out, data_out, data_oe, isr, irr_clear,
               rotate_valid, rotate_level, spurious, dbg_state
    );

    modport slave (
        input  req_valid, req_level, icw2_base, aeoi, inta_n,
               eoi_valid, eoi_specific, eoi_level, eoi_rotate,
        output int_out, data_out, data_oe, isr, irr_clear,
               rotate_valid, rotate_level, spurious, dbg_state
    );

endinterface

// File: rtl/interrupt_ack_sequencer_isr_highest_find.sv
// Lowest-set-bit finder over the ISR: the lowest index is the highest
// priority level currently in service.
module isr_highest_find
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [NUM_IRQ-1:0] vec_i,
    output logic               found_o,
    output logic [LVL_W-1:0]   idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = LVL_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Raises INT for a permitted request, runs the two-pulse 8086 INTA handshake,
// maintains the ISR and services EOI/AEOI with optional rotation feedback.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    interrupt_ack_sequencer_if.slave        bus
);

    state_e             state_q, state_d;
    logic               inta_hist_q;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic               spur_q, spur_d;
    logic               int_q, int_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] irr_clr_q, irr_clr_d;
    logic               rot_v_q, rot_v_d;
    logic [LVL_W-1:0]   rot_l_q, rot_l_d;
    logic               spur_p_q, spur_p_d;

    logic               fall, rise, permitted;
    logic               hi_found;
    logic [LVL_W-1:0]   hi_idx;
    logic               eoi_hit;
    logic [LVL_W-1:0]   eoi_lvl;
    logic [NUM_IRQ-1:0] set_mask, clr_mask;

    // One finder on the pre-update ISR serves both the nesting check and non-specific EOI.
    isr_highest_find u_find (
        .vec_i   (isr_q),
        .found_o (hi_found),
        .idx_o   (hi_idx)
    );

    always_comb begin
        fall      = inta_hist_q & ~bus.inta_n;
        rise      = ~inta_hist_q & bus.inta_n;
        permitted = bus.req_valid && !(hi_found && (hi_idx <= bus.req_level));

        state_d   = state_q;
        lvl_d     = lvl_q;
        spur_d    = spur_q;
        int_d     = int_q;
        set_mask  = '0;
        clr_mask  = '0;
        irr_clr_d = '0;
        spur_p_d  = 1'b0;
        rot_v_d   = 1'b0;
        rot_l_d   = rot_l_q;
        eoi_hit   = 1'b0;
        eoi_lvl   = '0;

        case (state_q)
            IDLE: begin
                if (permitted) begin
                    state_d = INT_PEND;
                    int_d   = 1'b1;
                end
            end
            INT_PEND: begin
                if (fall) begin
                    state_d = WAIT2;
                    int_d   = 1'b0;
                    if (permitted) begin
                        lvl_d     = bus.req_level;
                        spur_d    = 1'b0;
                        set_mask  = lvl_mask(bus.req_level);
                        irr_clr_d = lvl_mask(bus.req_level);
                    end else begin
                        lvl_d    = SPURIOUS_LVL;
                        spur_d   = 1'b1;
                        spur_p_d = 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (fall) state_d = VEC;
            end
            VEC: begin
                if (rise) begin
                    state_d = IDLE;
                    if (bus.aeoi && !spur_q) clr_mask = lvl_mask(lvl_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                eoi_hit = isr_q[bus.eoi_level];
                eoi_lvl = bus.eoi_level;
            end else begin
                eoi_hit = hi_found;
                eoi_lvl = hi_idx;
            end
        end
        if (eoi_hit) begin
            clr_mask = clr_mask | lvl_mask(eoi_lvl);
            if (bus.eoi_rotate) begin
                rot_v_d = 1'b1;
                rot_l_d = eoi_lvl;
            end
        end

        // A set and a clear of the same bit in one cycle resolves to set.
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            inta_hist_q <= 1'b1;
            lvl_q       <= '0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            isr_q       <= '0;
            irr_clr_q   <= '0;
            rot_v_q     <= 1'b0;
            rot_l_q     <= '0;
            spur_p_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_hist_q <= bus.inta_n;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
            int_q       <= int_d;
            isr_q       <= isr_d;
            irr_clr_q   <= irr_clr_d;
            rot_v_q     <= rot_v_d;
            rot_l_q     <= rot_l_d;
            spur_p_q    <= spur_p_d;
        end
    end

    // The vector drives the bus from the cycle the second fall is seen until INTA rises.
    always_comb begin
        bus.data_oe  = !reset && (((state_q == WAIT2) && fall) ||
                                  ((state_q == VEC) && !bus.inta_n));
        bus.data_out = bus.data_oe ? {bus.icw2_base, lvl_q} : 8'h00;
    end

    assign bus.int_out      = int_q;
    assign bus.isr          = isr_q;
    assign bus.irr_clear    = irr_clr_q;
    assign bus.rotate_valid = rot_v_q;
    assign bus.rotate_level = rot_l_q;
    assign bus.spurious     = spur_p_q;
    assign bus.dbg_state    = state_q;

endmodule
